// File: rtl/alu_cmd_sequencer.sv
// ALU command sequencer: decodes UART command frames, loads operands into the
// register file, runs one ALU operation and streams the two-byte result
// (LSB first) into the TX FIFO.
module alu_cmd_sequencer #(
    parameter int DATA_WIDTH     = 8,
    parameter int ALU_FUNC_WIDTH = 4,
    parameter int ADDR_WIDTH     = 4,
    parameter int OPA_ADDR       = 0,
    parameter int OPB_ADDR       = 1,
    parameter int TIMEOUT        = 16
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      rx_valid,
    input  logic [DATA_WIDTH-1:0]     rx_data,
    output logic                      busy,
    output logic                      rf_wr_en,
    output logic [ADDR_WIDTH-1:0]     rf_addr,
    output logic [DATA_WIDTH-1:0]     rf_wr_data,
    output logic [ALU_FUNC_WIDTH-1:0] alu_func,
    output logic                      alu_en,
    output logic                      alu_clk_en,
    input  logic [2*DATA_WIDTH-1:0]   alu_out,
    input  logic                      alu_valid,
    input  logic                      fifo_full,
    output logic                      fifo_wr,
    output logic [DATA_WIDTH-1:0]     fifo_wdata,
    output logic                      done,
    output logic                      err
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [DATA_WIDTH-1:0] CMD_FULL = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_FUNC = DATA_WIDTH'(8'hDD);

    typedef enum logic [2:0] {
        IDLE,
        GET_OPA,
        GET_OPB,
        GET_FUNC,
        ALU_START,
        WAIT_ALU,
        SEND_LSB,
        SEND_MSB
    } state_t;

    state_t                    state_reg;
    logic [ALU_FUNC_WIDTH-1:0] func_reg;
    logic [2*DATA_WIDTH-1:0]   result_reg;
    logic [CNT_W-1:0]          cnt_reg;
    logic                      busy_reg;
    logic                      alu_en_reg;
    logic                      alu_clk_en_reg;
    logic                      done_reg;
    logic                      err_reg;

    // Latched result split into its two transmit bytes (index 0 = LSB).
    logic [DATA_WIDTH-1:0] result_byte [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_result_byte
            assign result_byte[gi] = result_reg[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Main FSM with registered control outputs; counter tracks cycles spent in WAIT_ALU.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg      <= IDLE;
            func_reg       <= '0;
            result_reg     <= '0;
            cnt_reg        <= '0;
            busy_reg       <= 1'b0;
            alu_en_reg     <= 1'b0;
            alu_clk_en_reg <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
            alu_en_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (rx_valid && rx_data == CMD_FULL) begin
                        state_reg <= GET_OPA;
                        busy_reg  <= 1'b1;
                    end else if (rx_valid && rx_data == CMD_FUNC) begin
                        state_reg <= GET_FUNC;
                        busy_reg  <= 1'b1;
                    end
                end
                GET_OPA: begin
                    if (rx_valid) begin
                        state_reg <= GET_OPB;
                    end
                end
                GET_OPB: begin
                    if (rx_valid) begin
                        state_reg <= GET_FUNC;
                    end
                end
                GET_FUNC: begin
                    if (rx_valid) begin
                        func_reg       <= rx_data[ALU_FUNC_WIDTH-1:0];
                        state_reg      <= ALU_START;
                        alu_en_reg     <= 1'b1;
                        alu_clk_en_reg <= 1'b1;
                    end
                end
                ALU_START: begin
                    cnt_reg   <= '0;
                    state_reg <= WAIT_ALU;
                end
                WAIT_ALU: begin
                    // A valid result wins over a timeout expiring in the same cycle.
                    if (alu_valid) begin
                        result_reg     <= alu_out;
                        state_reg      <= SEND_LSB;
                        alu_clk_en_reg <= 1'b0;
                    end else if (cnt_reg == CNT_W'(TIMEOUT - 2)) begin
                        // Counter would step to TIMEOUT-1 here: give up, err lands TIMEOUT cycles after alu_en.
                        err_reg        <= 1'b1;
                        state_reg      <= IDLE;
                        busy_reg       <= 1'b0;
                        alu_clk_en_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                SEND_LSB: begin
                    if (!fifo_full) begin
                        state_reg <= SEND_MSB;
                    end
                end
                SEND_MSB: begin
                    if (!fifo_full) begin
                        done_reg  <= 1'b1;
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg      <= IDLE;
                    busy_reg       <= 1'b0;
                    alu_clk_en_reg <= 1'b0;
                end
            endcase
        end
    end

    // Same-cycle regfile write while an operand byte is being received; zero otherwise.
    always_comb begin
        rf_wr_en   = 1'b0;
        rf_addr    = '0;
        rf_wr_data = '0;
        if (rx_valid && (state_reg == GET_OPA || state_reg == GET_OPB)) begin
            rf_wr_en   = 1'b1;
            rf_addr    = (state_reg == GET_OPB) ? ADDR_WIDTH'(OPB_ADDR) : ADDR_WIDTH'(OPA_ADDR);
            rf_wr_data = rx_data;
        end
    end

    // FIFO write only when space is available; data held steady through a stall.
    always_comb begin
        fifo_wr    = 1'b0;
        fifo_wdata = '0;
        if (state_reg == SEND_LSB) begin
            fifo_wdata = result_byte[0];
            fifo_wr    = !fifo_full;
        end else if (state_reg == SEND_MSB) begin
            fifo_wdata = result_byte[1];
            fifo_wr    = !fifo_full;
        end
    end

    assign busy       = busy_reg;
    assign alu_func   = func_reg;
    assign alu_en     = alu_en_reg;
    assign alu_clk_en = alu_clk_en_reg;
    assign done       = done_reg;
    assign err        = err_reg;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed testbench for alu_cmd_sequencer: hand-computed per-cycle expectations.
module tb_alu_cmd_sequencer;

    localparam int TIMEOUT = 16;

    logic        CLK;
    logic        RST;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        busy;
    logic        rf_wr_en;
    logic [3:0]  rf_addr;
    logic [7:0]  rf_wr_data;
    logic [3:0]  alu_func;
    logic        alu_en;
    logic        alu_clk_en;
    logic [15:0] alu_out;
    logic        alu_valid;
    logic        fifo_full;
    logic        fifo_wr;
    logic [7:0]  fifo_wdata;
    logic        done;
    logic        err;

    int n_cmp = 0;
    int n_mis = 0;

    alu_cmd_sequencer #(
        .DATA_WIDTH    (8),
        .ALU_FUNC_WIDTH(4),
        .ADDR_WIDTH    (4),
        .OPA_ADDR      (0),
        .OPB_ADDR      (1),
        .TIMEOUT       (TIMEOUT)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .busy      (busy),
        .rf_wr_en  (rf_wr_en),
        .rf_addr   (rf_addr),
        .rf_wr_data(rf_wr_data),
        .alu_func  (alu_func),
        .alu_en    (alu_en),
        .alu_clk_en(alu_clk_en),
        .alu_out   (alu_out),
        .alu_valid (alu_valid),
        .fifo_full (fifo_full),
        .fifo_wr   (fifo_wr),
        .fifo_wdata(fifo_wdata),
        .done      (done),
        .err       (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge; return mid-cycle for sampling.
    task automatic cycle(input logic v, input logic [7:0] d, input logic av,
                         input logic [15:0] ao, input logic ff);
        @(posedge CLK);
        #1;
        rx_valid  = v;
        rx_data   = d;
        alu_valid = av;
        alu_out   = ao;
        fifo_full = ff;
        #3;
    endtask

    task automatic outs(input string tag, input logic e_busy, input logic e_rfwe,
                        input logic e_aen, input logic e_cen, input logic e_fwr,
                        input logic [7:0] e_wdata, input logic e_done, input logic e_err);
        check({tag, ".busy"},       32'(busy),       32'(e_busy));
        check({tag, ".rf_wr_en"},   32'(rf_wr_en),   32'(e_rfwe));
        check({tag, ".alu_en"},     32'(alu_en),     32'(e_aen));
        check({tag, ".alu_clk_en"}, 32'(alu_clk_en), 32'(e_cen));
        check({tag, ".fifo_wr"},    32'(fifo_wr),    32'(e_fwr));
        check({tag, ".fifo_wdata"}, 32'(fifo_wdata), 32'(e_wdata));
        check({tag, ".done"},       32'(done),       32'(e_done));
        check({tag, ".err"},        32'(err),        32'(e_err));
    endtask

    initial begin
        RST       = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'hAB;
        alu_valid = 1'b0;
        alu_out   = 16'hFFFF;
        fifo_full = 1'b0;

        // Reset state
        repeat (2) @(posedge CLK);
        #4;
        outs("rst", 0, 0, 0, 0, 0, 8'h00, 0, 0);
        check("rst.rf_addr", 32'(rf_addr), 32'h0);
        check("rst.rf_wr_data", 32'(rf_wr_data), 32'h0);
        check("rst.alu_func", 32'(alu_func), 32'h0);
        @(posedge CLK);
        #1;
        RST     = 1'b1;
        rx_data = 8'h00;
        alu_out = 16'h0000;
        $display("txn reset done");

        // CC,05,03,00 with result 0x0008 at alu_en+2
        cycle(1, 8'hCC, 0, 16'h0000, 0); outs("t1_cc", 0, 0, 0, 0, 0, 8'h00, 0, 0);
        cycle(1, 8'h05, 0, 16'h0000, 0); outs("t1_opa", 1, 1, 0, 0, 0, 8'h00, 0, 0);
        check("t1_opa.rf_addr", 32'(rf_addr), 32'h0);
        check("t1_opa.rf_wr_data", 32'(rf_wr_data), 32'h05);
        cycle(1, 8'h03, 0, 16'h0000, 0); outs("t1_opb", 1, 1, 0, 0, 0, 8'h00, 0, 0);
        check("t1_opb.rf_addr", 32'(rf_addr), 32'h1);
        check("t1_opb.rf_wr_data", 32'(rf_wr_data), 32'h03);
        cycle(1, 8'h00, 0, 16'h0000, 0); outs("t1_func", 1, 0, 0, 0, 0, 8'h00, 0, 0);
        cycle(0, 8'h00, 0, 16'h0000, 0); outs("t1_start", 1, 0, 1, 1, 0, 8'h00, 0, 0);
        check("t1_start.alu_func", 32'(alu_func), 32'h0);
        cycle(0, 8'h00, 0, 16'h0000, 0); outs("t1_wait", 1, 0, 0, 1, 0, 8'h00, 0, 0);
        cycle(0, 8'h00, 1, 16'h0008, 0); outs("t1_valid", 1, 0, 0, 1, 0, 8'h00, 0, 0);
        cycle(0, 8'h00, 0, 16'hFFFF, 0); outs("t1_lsb", 1, 0, 0, 0, 1, 8'h08, 0, 0);
        cycle(0, 8'h00, 0, 16'hFFFF, 0); outs("t1_msb", 1, 0, 0, 0, 1, 8'h00, 0, 0);
        cycle(0, 8'h00, 0, 16'hFFFF, 0); outs("t1_done", 0, 0, 0, 0, 0, 8'h00, 1, 0);
        cycle(0, 8'h00, 0, 16'h0000, 0); outs("t1_idle", 0, 0, 0, 0, 0, 8'h00, 0, 0);
        $display("txn CC 05 03 00 -> fifo 08 00");

        // Ignored 0x55, then DD,F2 (func 2), stray rx in WAIT, result 0x1234
        cycle(1, 8'h55, 0, 16'h0000, 0); outs("t2_ign", 0, 0, 0, 0, 0, 8'h00, 0, 0);
        cycle(1, 8'hDD, 0, 16'h0000, 0); outs("t2_dd", 0, 0, 0, 0, 0, 8'h00, 0, 0);
        cycle(1, 8'hF2, 0, 16'h0000, 0); outs("t2_func", 1, 0, 0, 0, 0, 8'h00, 0, 0);
        cycle(0, 8'h00, 0, 16'h0000, 0); outs("t2_start", 1, 0, 1, 1, 0, 8'h00, 0, 0);
        check("t2_start.alu_func", 32'(alu_func), 32'h2);
        cycle(1, 8'h77, 0, 16'h0000, 0); outs("t2_wait_rx", 1, 0, 0, 1, 0, 8'h00, 0, 0);
        cycle(0, 8'h00, 1, 16'h1234, 0); outs("t2_valid", 1, 0, 0, 1, 0, 8'h00, 0, 0);
        check("t2_valid.alu_func", 32'(alu_func), 32'h2);
        cycle(0, 8'h00, 1, 16'h5678, 0); outs("t2_lsb", 1, 0, 0, 0, 1, 8'h34, 0, 0);
        cycle(0, 8'h00, 0, 16'h0000, 0); outs("t2_msb", 1, 0, 0, 0, 1, 8'h12, 0, 0);
        cycle(0, 8'h00, 0, 16'h0000, 0); outs("t2_done", 0, 0, 0, 0, 0, 8'h00, 1, 0);
        $display("txn 55 ignored; DD F2 -> fifo 34 12");

        // FIFO full for 5 cycles at SEND_LSB, result 0xBEEF
        cycle(1, 8'hDD, 0, 16'h0000, 0);
        cycle(1, 8'h03, 0, 16'h0000, 0);
        cycle(0, 8'h00, 0, 16'h0000, 0); outs("t3_start", 1, 0, 1, 1, 0, 8'h00, 0, 0);
        cycle(0, 8'h00, 1, 16'hBEEF, 0); outs("t3_valid", 1, 0, 0, 1, 0, 8'h00, 0, 0);
        for (int k = 0; k < 5; k++) begin
            cycle(0, 8'h00, 1, 16'h0000, 1);
            outs("t3_stall", 1, 0, 0, 0, 0, 8'hEF, 0, 0);
        end
        cycle(0, 8'h00, 0, 16'h0000, 0); outs("t3_lsb", 1, 0, 0, 0, 1, 8'hEF, 0, 0);
        cycle(0, 8'h00, 0, 16'h0000, 0); outs("t3_msb", 1, 0, 0, 0, 1, 8'hBE, 0, 0);
        cycle(0, 8'h00, 0, 16'h0000, 0); outs("t3_done", 0, 0, 0, 0, 0, 8'h00, 1, 0);
        $display("txn DD 03 with 5-cycle fifo stall -> fifo EF BE");

        // Timeout: CC,11,22,01 and alu_valid never arrives
        cycle(1, 8'hCC, 0, 16'h0000, 0);
        cycle(1, 8'h11, 0, 16'h0000, 0);
        cycle(1, 8'h22, 0, 16'h0000, 0);
        cycle(1, 8'h01, 0, 16'h0000, 0);
        cycle(0, 8'h00, 0, 16'h0000, 0); outs("t4_start", 1, 0, 1, 1, 0, 8'h00, 0, 0);
        check("t4_start.alu_func", 32'(alu_func), 32'h1);
        for (int k = 1; k < TIMEOUT; k++) begin
            cycle(0, 8'h00, 0, 16'h0000, 0);
            outs("t4_wait", 1, 0, 0, 1, 0, 8'h00, 0, 0);
        end
        cycle(0, 8'h00, 0, 16'h0000, 0); outs("t4_err", 0, 0, 0, 0, 0, 8'h00, 0, 1);
        cycle(0, 8'h00, 0, 16'h0000, 0); outs("t4_after", 0, 0, 0, 0, 0, 8'h00, 0, 0);
        $display("txn CC 11 22 01 -> timeout err");

        // Asynchronous reset during WAIT_ALU, then a full command completes
        cycle(1, 8'hDD, 0, 16'h0000, 0);
        cycle(1, 8'h04, 0, 16'h0000, 0);
        cycle(0, 8'h00, 0, 16'h0000, 0); outs("t5_start", 1, 0, 1, 1, 0, 8'h00, 0, 0);
        cycle(0, 8'h00, 0, 16'h0000, 0); outs("t5_wait", 1, 0, 0, 1, 0, 8'h00, 0, 0);
        #1;
        RST = 1'b0;
        #1;
        outs("t5_rst", 0, 0, 0, 0, 0, 8'h00, 0, 0);
        check("t5_rst.alu_func", 32'(alu_func), 32'h0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        cycle(1, 8'hCC, 0, 16'h0000, 0); outs("t5_cc", 0, 0, 0, 0, 0, 8'h00, 0, 0);
        cycle(1, 8'h05, 0, 16'h0000, 0); outs("t5_opa", 1, 1, 0, 0, 0, 8'h00, 0, 0);
        check("t5_opa.rf_wr_data", 32'(rf_wr_data), 32'h05);
        cycle(1, 8'h03, 0, 16'h0000, 0); outs("t5_opb", 1, 1, 0, 0, 0, 8'h00, 0, 0);
        check("t5_opb.rf_addr", 32'(rf_addr), 32'h1);
        cycle(1, 8'h00, 0, 16'h0000, 0);
        cycle(0, 8'h00, 0, 16'h0000, 0); outs("t5_start2", 1, 0, 1, 1, 0, 8'h00, 0, 0);
        cycle(0, 8'h00, 0, 16'h0000, 0);
        cycle(0, 8'h00, 1, 16'h0008, 0);
        cycle(0, 8'h00, 0, 16'h0000, 0); outs("t5_lsb", 1, 0, 0, 0, 1, 8'h08, 0, 0);
        cycle(0, 8'h00, 0, 16'h0000, 0); outs("t5_msb", 1, 0, 0, 0, 1, 8'h00, 0, 0);
        cycle(0, 8'h00, 0, 16'h0000, 0); outs("t5_done", 0, 0, 0, 0, 0, 8'h00, 1, 0);
        $display("txn reset in WAIT_ALU; CC 05 03 00 -> fifo 08 00");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
